fetch_unit: RTL

Instruction fetch stage sitting directly upstream of the processor's word-addressed instruction memory. It holds the program counter and issues read strobes to the memory. It captures the word the memory returns one cycle later and presents it, with its PC, to the decode stage through a valid/ready handshake. It also accepts PC redirects from branch and jump resolution, discarding any read already in flight.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a word-addressed instruction memory.
// Holds the PC and issues one read at a time. Captures the returned word one
// cycle later and offers it, with its PC, to decode over a valid/ready
// handshake. A redirect reloads the PC and discards any read in flight.
//
// Ports:
//   clk            system clock, rising-edge active
//   resetn         asynchronous active-low reset
//   mem_addr       byte address to memory (always the PC, word aligned)
//   mem_rstrb      read request, data returns after the next rising edge
//   mem_rdata      word returned by memory
//   instr          captured instruction word
//   instr_pc       address instr was fetched from
//   instr_valid    instr/instr_pc valid for decode
//   instr_ready    decode accepts instr when high together with instr_valid
//   redirect_valid load redirect_pc as the new PC this cycle
//   redirect_pc    redirect target, low two bits ignored
//   fetch_count    instructions accepted by decode, wraps modulo 2^32
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] count_q, count_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      pc_q       <= RESET_ADDR;
      instr_q    <= 32'h0;
      instr_pc_q <= 32'h0;
      count_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;

    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: state_d = StWait;
      StWait: begin
        instr_d    = mem_rdata;
        instr_pc_d = pc_q;
        state_d    = StHold;
      end
      StHold: begin
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          count_d = count_q + 32'd1;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect wins over everything except the accept count: an instruction
    // handed to decode in the same cycle still counts as consumed.
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~32'd3;
      state_d    = StFetch;
      instr_d    = instr_q;
      instr_pc_d = instr_pc_q;
    end
  end

  assign mem_addr    = pc_q;
  assign mem_rstrb   = (state_q == StFetch);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = (state_q == StHold);
  assign fetch_count = count_q;

endmodule
